// File: rtl/stage4_fast_serializer.sv
// -----------------------------------------------------------------------------
// stage4_fast_serializer
//
// Purpose:
//   Takes one block of three encoded FAST messages from the stage-3 field
//   encoder. Each message is left-aligned, with its presence map in the top
//   16 bits, and comes with a byte length. The block is streamed out one
//   byte at a time, MSB-first: the valid bytes of message 1, then message 2,
//   then message 3. Only one block is held at a time.
//
// Ports:
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset (released synchronously upstream)
//   in_valid / in_ready     block handshake; a block is taken when both are high
//   message_fast_1..3       encoded messages, MSB-aligned, MSG_BITS wide
//   message_fast_length_1..3 valid byte count per message, LEN_BITS wide
//   out_data                current output byte
//   out_valid / out_ready   byte handshake toward the transmit stage
//   out_msg_end             marks the final byte of each message
//   out_last                marks the final byte of the block
//   len_err                 one-cycle pulse after accept if any length > MAX_LEN
//   blk_count               number of completed blocks (wraps)
// -----------------------------------------------------------------------------
module stage4_fast_serializer #(
    parameter int MSG_BITS = 344,
    parameter int LEN_BITS = 8,
    parameter int MAX_LEN  = MSG_BITS / 8,
    parameter int CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MSG_BITS-1:0] message_fast_1,
    input  logic [MSG_BITS-1:0] message_fast_2,
    input  logic [MSG_BITS-1:0] message_fast_3,
    input  logic [LEN_BITS-1:0] message_fast_length_1,
    input  logic [LEN_BITS-1:0] message_fast_length_2,
    input  logic [LEN_BITS-1:0] message_fast_length_3,
    output logic [7:0]          out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_msg_end,
    output logic                out_last,
    output logic                len_err,
    output logic [CNT_BITS-1:0] blk_count
);

    // Byte counter width: it only has to reach MAX_LEN-1.
    localparam int CW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [LEN_BITS-1:0] MAX_LEN_L = LEN_BITS'(MAX_LEN);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // Input gathering and length saturation
    // -------------------------------------------------------------------------
    logic [MSG_BITS-1:0] msg_in  [3];
    logic [LEN_BITS-1:0] len_in  [3];
    logic [LEN_BITS-1:0] len_sat [3];
    logic [2:0]          len_over;

    assign msg_in[0] = message_fast_1;
    assign msg_in[1] = message_fast_2;
    assign msg_in[2] = message_fast_3;
    assign len_in[0] = message_fast_length_1;
    assign len_in[1] = message_fast_length_2;
    assign len_in[2] = message_fast_length_3;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_len
            assign len_over[gi] = (len_in[gi] > MAX_LEN_L);
            assign len_sat[gi]  = len_over[gi] ? MAX_LEN_L : len_in[gi];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [MSG_BITS-1:0] msg_q [3];
    logic [MSG_BITS-1:0] msg_d [3];
    logic [LEN_BITS-1:0] len_q [3];
    logic [LEN_BITS-1:0] len_d [3];
    logic [1:0]          idx_q, idx_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                len_err_q, len_err_d;
    logic [CNT_BITS-1:0] blk_count_q, blk_count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            len_err_q   <= 1'b0;
            blk_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            len_err_q   <= len_err_d;
            blk_count_q <= blk_count_d;
        end
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_cap
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    msg_q[gi] <= '0;
                    len_q[gi] <= '0;
                end else begin
                    msg_q[gi] <= msg_d[gi];
                    len_q[gi] <= len_d[gi];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Current message selection and byte extraction
    // -------------------------------------------------------------------------
    logic [MSG_BITS-1:0] msg_cur;
    logic [LEN_BITS-1:0] len_cur;
    logic                later_zero;   // no later message in the block carries bytes
    logic [7:0]          byte_arr [MAX_LEN];
    logic [7:0]          cur_byte;
    logic                last_byte;

    always_comb begin
        msg_cur    = msg_q[2];
        len_cur    = len_q[2];
        later_zero = 1'b1;
        case (idx_q)
            2'd0: begin
                msg_cur    = msg_q[0];
                len_cur    = len_q[0];
                later_zero = (len_q[1] == '0) && (len_q[2] == '0);
            end
            2'd1: begin
                msg_cur    = msg_q[1];
                len_cur    = len_q[1];
                later_zero = (len_q[2] == '0);
            end
            default: begin
                msg_cur    = msg_q[2];
                len_cur    = len_q[2];
                later_zero = 1'b1;
            end
        endcase
    end

    // Byte k of the message sits at bits [MSG_BITS-1-8k -: 8].
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_bytes
            assign byte_arr[gi] = msg_cur[MSG_BITS-1-8*gi -: 8];
        end
    endgenerate

    always_comb begin
        cur_byte = byte_arr[0];
        for (int k = 1; k < MAX_LEN; k++) begin
            if (cnt_q == CW'(k)) begin
                cur_byte = byte_arr[k];
            end
        end
    end

    assign last_byte = (LEN_BITS'(cnt_q) == (len_cur - LEN_BITS'(1)));

    // -------------------------------------------------------------------------
    // Next-state and outputs
    // -------------------------------------------------------------------------
    logic advance;   // current message finished (last byte sent or skipped)

    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        len_err_d   = 1'b0;
        blk_count_d = blk_count_q;
        advance     = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = 8'h00;
        out_msg_end = 1'b0;
        out_last    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    msg_d     = msg_in;
                    len_d     = len_sat;
                    idx_d     = 2'd0;
                    cnt_d     = '0;
                    len_err_d = |len_over;
                    state_d   = SEND;
                end
            end

            SEND: begin
                if (len_cur == '0) begin
                    // Empty message: spend one bubble cycle and move on.
                    advance = 1'b1;
                end else begin
                    out_valid   = 1'b1;
                    out_data    = cur_byte;
                    out_msg_end = last_byte;
                    out_last    = last_byte && later_zero;
                    if (out_ready) begin
                        if (last_byte) begin
                            advance = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end

                if (advance) begin
                    cnt_d = '0;
                    if (idx_q == 2'd2) begin
                        idx_d       = 2'd0;
                        state_d     = IDLE;
                        blk_count_d = blk_count_q + CNT_BITS'(1);
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign len_err   = len_err_q;
    assign blk_count = blk_count_q;

endmodule

// File: tb/tb_stage4_fast_serializer.sv
// -----------------------------------------------------------------------------
// tb_stage4_fast_serializer
//
// Directed bench for stage4_fast_serializer. Each scenario loads a block,
// records the output stream cycle by cycle starting the cycle after accept,
// and compares it against a hand-built expected table.
// -----------------------------------------------------------------------------
module tb_stage4_fast_serializer;

    localparam int MSG_BITS = 344;
    localparam int LEN_BITS = 8;
    localparam int CNT_BITS = 16;
    localparam int TRMAX    = 128;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [MSG_BITS-1:0] message_fast_1;
    logic [MSG_BITS-1:0] message_fast_2;
    logic [MSG_BITS-1:0] message_fast_3;
    logic [LEN_BITS-1:0] message_fast_length_1;
    logic [LEN_BITS-1:0] message_fast_length_2;
    logic [LEN_BITS-1:0] message_fast_length_3;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready;
    logic                out_msg_end;
    logic                out_last;
    logic                len_err;
    logic [CNT_BITS-1:0] blk_count;

    stage4_fast_serializer dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .message_fast_1        (message_fast_1),
        .message_fast_2        (message_fast_2),
        .message_fast_3        (message_fast_3),
        .message_fast_length_1 (message_fast_length_1),
        .message_fast_length_2 (message_fast_length_2),
        .message_fast_length_3 (message_fast_length_3),
        .out_data              (out_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_msg_end           (out_msg_end),
        .out_last              (out_last),
        .len_err               (len_err),
        .blk_count             (blk_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_blk  = 0;

    // Recorded trace, index 0 = first cycle after accept.
    logic       tr_valid   [TRMAX];
    logic [7:0] tr_data    [TRMAX];
    logic       tr_end     [TRMAX];
    logic       tr_last    [TRMAX];
    logic       tr_lenerr  [TRMAX];
    logic       tr_inready [TRMAX];
    int         done_cyc;

    // Expected {valid, msg_end, last, data}; bubble cycles are all zero.
    logic [10:0] exp_tr [TRMAX];

    // Block used by most scenarios; lower bytes are filler that must never appear.
    logic [7:0] s1b [10] = '{8'hF0, 8'h00, 8'hB0, 8'h00, 8'h5A,
                             8'h80, 8'h00, 8'h11, 8'h22, 8'h33};
    logic [MSG_BITS-1:0] m1 = {8'hF0, 8'h00, {41{8'hEE}}};
    logic [MSG_BITS-1:0] m2 = {8'hB0, 8'h00, 8'h5A, {40{8'hEE}}};
    logic [MSG_BITS-1:0] m3 = {8'h80, 8'h00, 8'h11, 8'h22, 8'h33, {38{8'hEE}}};

    function automatic logic [10:0] ev(input logic v, input logic e,
                                       input logic l, input logic [7:0] d);
        return {v, e, l, d};
    endfunction

    function automatic logic [10:0] obs(input int c);
        return tr_valid[c] ? {1'b1, tr_end[c], tr_last[c], tr_data[c]} : 11'h000;
    endfunction

    task automatic load_block(input logic [MSG_BITS-1:0] a, input logic [MSG_BITS-1:0] b,
                              input logic [MSG_BITS-1:0] c, input int la,
                              input int lb, input int lc);
        message_fast_1        = a;
        message_fast_2        = b;
        message_fast_3        = c;
        message_fast_length_1 = LEN_BITS'(la);
        message_fast_length_2 = LEN_BITS'(lb);
        message_fast_length_3 = LEN_BITS'(lc);
    endtask

    // Presents in_valid for one cycle; returns at the negedge after accept.
    task automatic send_block();
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Records outputs once per cycle until in_ready returns or the budget runs out.
    task automatic collect(input int max_cyc, input bit bp, input bit busy);
        done_cyc = -1;
        for (int c = 0; c < max_cyc && c < TRMAX; c++) begin
            tr_valid[c]   = out_valid;
            tr_data[c]    = out_data;
            tr_end[c]     = out_msg_end;
            tr_last[c]    = out_last;
            tr_lenerr[c]  = len_err;
            tr_inready[c] = in_ready;
            if (in_ready) begin
                done_cyc  = c;
                out_ready = 1'b0;
                in_valid  = 1'b0;
                break;
            end
            out_ready = bp ? (c % 2 == 1) : 1'b1;
            if (busy && (c == 2 || c == 3)) begin
                load_block({43{8'hAA}}, {43{8'hAB}}, {43{8'hAC}}, 1, 1, 1);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        load_block('0, '0, '0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, out_msg_end, out_last, len_err} !== 13'b1_0_00000000_0_0_0) begin
            failures++;
            $display("FAIL reset_outputs: got in_ready=%b out_valid=%b data=%h end=%b last=%b len_err=%b, want 1 0 00 0 0 0",
                     in_ready, out_valid, out_data, out_msg_end, out_last, len_err);
        end
        checks++;
        if (blk_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_blk_count: got %0d want 0", blk_count);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        $display("reset: in_ready=%b out_valid=%b blk_count=%0d", in_ready, out_valid, blk_count);
    endtask

    task automatic test_contiguous();
        load_block(m1, m2, m3, 2, 3, 5);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL contig_in_ready_idle: got %b want 1", in_ready);
        end
        send_block();
        collect(60, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) exp_tr[c] = ev(1'b1, (c == 1 || c == 4 || c == 9), (c == 9), s1b[c]);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL contig_byte%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if (done_cyc !== 10) begin
            failures++;
            $display("FAIL contig_done_cycle: got %0d want 10", done_cyc);
        end
        checks++;
        if (tr_lenerr[0] !== 1'b0) begin
            failures++;
            $display("FAIL contig_len_err: got %b want 0", tr_lenerr[0]);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL contig_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block contiguous: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_backpressure();
        load_block(m1, m2, m3, 2, 3, 5);
        send_block();
        collect(80, 1'b1, 1'b0);
        // Ready pattern 0,1,0,1...: every byte is shown for a stall cycle then taken.
        for (int c = 0; c < 20; c++) exp_tr[c] = ev(1'b1, (c/2 == 1 || c/2 == 4 || c/2 == 9), (c/2 == 9), s1b[c/2]);
        for (int c = 0; c < 20; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL bp_cycle%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if (done_cyc !== 20) begin
            failures++;
            $display("FAIL bp_done_cycle: got %0d want 20", done_cyc);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL bp_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block backpressure: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_zero_middle();
        load_block(m1, m2, m3, 2, 0, 5);
        send_block();
        collect(60, 1'b0, 1'b0);
        exp_tr[0] = ev(1'b1, 1'b0, 1'b0, 8'hF0);
        exp_tr[1] = ev(1'b1, 1'b1, 1'b0, 8'h00);
        exp_tr[2] = 11'h000;
        for (int c = 3; c < 8; c++) exp_tr[c] = ev(1'b1, (c == 7), (c == 7), s1b[c + 2]);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL zmid_cycle%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if (done_cyc !== 8) begin
            failures++;
            $display("FAIL zmid_done_cycle: got %0d want 8", done_cyc);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL zmid_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block zero_middle: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_over_length();
        logic [MSG_BITS-1:0] mo;
        mo = '0;
        for (int k = 0; k < 43; k++) mo[MSG_BITS-1-8*k -: 8] = 8'(k + 1);
        load_block(mo, m2, m3, 60, 0, 0);
        send_block();
        collect(100, 1'b0, 1'b0);
        for (int c = 0; c < 43; c++) exp_tr[c] = ev(1'b1, (c == 42), (c == 42), 8'(c + 1));
        exp_tr[43] = 11'h000;
        exp_tr[44] = 11'h000;
        for (int c = 0; c < 45; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL ovl_cycle%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if (done_cyc !== 45) begin
            failures++;
            $display("FAIL ovl_done_cycle: got %0d want 45", done_cyc);
        end
        checks++;
        if ({tr_lenerr[0], tr_lenerr[1]} !== 2'b10) begin
            failures++;
            $display("FAIL ovl_len_err_pulse: got %b%b want 10", tr_lenerr[0], tr_lenerr[1]);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL ovl_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block over_length: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_all_zero();
        load_block(m1, m2, m3, 0, 0, 0);
        send_block();
        collect(20, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (obs(c) !== 11'h000) begin
                failures++;
                $display("FAIL zero_bubble%0d: got %h want 000", c, obs(c));
            end
        end
        checks++;
        if (done_cyc !== 3) begin
            failures++;
            $display("FAIL zero_done_cycle: got %0d want 3", done_cyc);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL zero_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block all_zero: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_busy_ignored();
        load_block(m1, m2, m3, 2, 3, 5);
        send_block();
        collect(60, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) exp_tr[c] = ev(1'b1, (c == 1 || c == 4 || c == 9), (c == 9), s1b[c]);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL busy_byte%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if ({tr_inready[2], tr_inready[3]} !== 2'b00) begin
            failures++;
            $display("FAIL busy_in_ready: got %b%b want 00", tr_inready[2], tr_inready[3]);
        end
        checks++;
        if (done_cyc !== 10) begin
            failures++;
            $display("FAIL busy_done_cycle: got %0d want 10", done_cyc);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL busy_no_stray_block: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL busy_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block busy_ignored: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    task automatic test_reset_mid();
        load_block(m1, m2, m3, 2, 3, 5);
        send_block();
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, blk_count} !== {1'b0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL rmid_during_reset: got out_valid=%b in_ready=%b blk=%0d want 0 1 0",
                     out_valid, in_ready, blk_count);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_blk = 0;
        checks++;
        if ({out_valid, in_ready, blk_count} !== {1'b0, 1'b1, 16'd0}) begin
            failures++;
            $display("FAIL rmid_after_release: got out_valid=%b in_ready=%b blk=%0d want 0 1 0",
                     out_valid, in_ready, blk_count);
        end
        load_block(m1, m2, m3, 2, 3, 5);
        send_block();
        collect(60, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) exp_tr[c] = ev(1'b1, (c == 1 || c == 4 || c == 9), (c == 9), s1b[c]);
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (obs(c) !== exp_tr[c]) begin
                failures++;
                $display("FAIL rmid_byte%0d: got %h want %h", c, obs(c), exp_tr[c]);
            end
        end
        checks++;
        if (done_cyc !== 10) begin
            failures++;
            $display("FAIL rmid_done_cycle: got %0d want 10", done_cyc);
        end
        exp_blk++;
        checks++;
        if (blk_count !== CNT_BITS'(exp_blk)) begin
            failures++;
            $display("FAIL rmid_blk_count: got %0d want %0d", blk_count, exp_blk);
        end
        $display("block reset_mid: cycles=%0d blk_count=%0d", done_cyc, blk_count);
    endtask

    initial begin
        test_reset();
        test_contiguous();
        test_backpressure();
        test_zero_middle();
        test_over_length();
        test_all_zero();
        test_busy_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

endmodule
